// File: rtl/pa_ctrl_pkg.sv
// Shared types and constants for the phase-accumulator sweep sequencer.
// Holds the FSM states, config register addresses and width defaults.
package pa_ctrl_pkg;

    localparam int W_DEF  = 16;
    localparam int CW_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic [2:0] ADDR_FCW_START  = 3'd0;
    localparam logic [2:0] ADDR_FCW_STEP   = 3'd1;
    localparam logic [2:0] ADDR_STEP_COUNT = 3'd2;
    localparam logic [2:0] ADDR_DWELL      = 3'd3;
    localparam logic [2:0] ADDR_INIT       = 3'd4;

endpackage

// File: rtl/pa_step_timer.sv
// Dwell and step down-counters for the frequency sweep.
// step_tick: dwell expired, more steps remain; last: final dwell expired.
module pa_step_timer
    import pa_ctrl_pkg::*;
#(
    parameter int CW = CW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] dwell_reload,
    input  logic [CW-1:0] step_init,
    output logic          step_tick,
    output logic          last
);

    logic [CW-1:0] dwell_cnt;
    logic [CW-1:0] step_cnt;
    logic          dwell_zero;
    logic          step_zero;

    assign dwell_zero = (dwell_cnt == '0);
    assign step_zero  = (step_cnt == '0);
    assign step_tick  = en && dwell_zero && !step_zero;
    assign last       = en && dwell_zero && step_zero;

    // Count down the dwell; on expiry consume one step and reload the dwell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_cnt <= '0;
            step_cnt  <= '0;
        end else if (load) begin
            dwell_cnt <= dwell_reload;
            step_cnt  <= step_init;
        end else if (en) begin
            if (!dwell_zero) begin
                dwell_cnt <= dwell_cnt - CW'(1);
            end else if (!step_zero) begin
                step_cnt  <= step_cnt - CW'(1);
                dwell_cnt <= dwell_reload;
            end
        end
    end

endmodule

// File: rtl/pa_sweep_ctrl.sv
// Stepped-frequency sweep sequencer driving the NCO phase accumulator.
// Owns the config bank, the control FSM and the FCW step adder.
module pa_sweep_ctrl
    import pa_ctrl_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int CW = CW_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cfg_we,
    input  logic [2:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         start,
    input  logic         abort,
    output logic [W-1:0] fcw,
    output logic [W-1:0] init,
    output logic         pa_load_n,
    output logic         wen,
    output logic         busy,
    output logic         done
);

    state_t        state;
    logic [W-1:0]  fcw_start;
    logic [W-1:0]  fcw_step;
    logic [W-1:0]  init_phase;
    logic [CW-1:0] step_count;
    logic [CW-1:0] dwell;
    logic [CW-1:0] dwell_reload;
    logic          step_tick;
    logic          last;

    // A zero dwell behaves as a dwell of one cycle.
    assign dwell_reload = (dwell == '0) ? '0 : dwell - CW'(1);

    pa_step_timer #(
        .CW(CW)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .load        (state == LOAD),
        .en          (state == RUN),
        .dwell_reload(dwell_reload),
        .step_init   (step_count),
        .step_tick   (step_tick),
        .last        (last)
    );

    // Config bank; only writable while idle so a running sweep is stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcw_start  <= '0;
            fcw_step   <= '0;
            step_count <= '0;
            dwell      <= CW'(1);
            init_phase <= '0;
        end else if (cfg_we && state == IDLE) begin
            case (cfg_addr)
                ADDR_FCW_START:  fcw_start  <= cfg_data;
                ADDR_FCW_STEP:   fcw_step   <= cfg_data;
                ADDR_STEP_COUNT: step_count <= CW'(cfg_data);
                ADDR_DWELL:      dwell      <= CW'(cfg_data);
                ADDR_INIT:       init_phase <= cfg_data;
                default:         ;
            endcase
        end
    end

    // Sweep FSM with registered accumulator and host outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            fcw       <= '0;
            init      <= '0;
            pa_load_n <= 1'b1;
            wen       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pa_load_n <= 1'b1;
            done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    fcw  <= '0;
                    wen  <= 1'b0;
                    busy <= 1'b0;
                    if (start && !abort) begin
                        state     <= LOAD;
                        pa_load_n <= 1'b0;
                        init      <= init_phase;
                        fcw       <= fcw_start;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        fcw   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        state <= RUN;
                        wen   <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        fcw   <= '0;
                        wen   <= 1'b0;
                        busy  <= 1'b0;
                    end else if (last) begin
                        state <= DONE;
                        fcw   <= '0;
                        wen   <= 1'b0;
                        done  <= 1'b1;
                    end else if (step_tick) begin
                        fcw <= fcw + fcw_step;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pa_sweep_ctrl.sv
// Directed bench for pa_sweep_ctrl with an expected-event scoreboard.
// Each active cycle (load, sample, done) is popped and compared.
module tb_pa_sweep_ctrl;

    localparam logic [1:0] K_LOAD = 2'd0;
    localparam logic [1:0] K_WEN  = 2'd1;
    localparam logic [1:0] K_DONE = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] fcw;
        logic [15:0] init;
    } ev_t;

    logic        clk;
    logic        reset;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        start;
    logic        abort;
    logic [15:0] fcw;
    logic [15:0] init;
    logic        pa_load_n;
    logic        wen;
    logic        busy;
    logic        done;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    pa_sweep_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .start    (start),
        .abort    (abort),
        .fcw      (fcw),
        .init     (init),
        .pa_load_n(pa_load_n),
        .wen      (wen),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] mon_kind;
    ev_t        mon_ev;

    always @(negedge clk) begin
        if (reset === 1'b1 && (!pa_load_n || wen || done)) begin
            mon_kind = !pa_load_n ? K_LOAD : (wen ? K_WEN : K_DONE);
            chk("one_active", 32'(!pa_load_n) + 32'(wen) + 32'(done), 1);
            chk("busy_active", 32'(busy), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(mon_kind), 32'hFF);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("kind", 32'(mon_kind), 32'(mon_ev.kind));
                chk("fcw", 32'(fcw), 32'(mon_ev.fcw));
                if (mon_ev.kind == K_LOAD)
                    chk("init", 32'(init), 32'(mon_ev.init));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(logic [2:0] a, logic [15:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_all(logic [15:0] fs, logic [15:0] st,
                           logic [15:0] n, logic [15:0] dw,
                           logic [15:0] ip);
        cfg_write(3'd0, fs);
        cfg_write(3'd1, st);
        cfg_write(3'd2, n);
        cfg_write(3'd3, dw);
        cfg_write(3'd4, ip);
    endtask

    // Push load plus the first nwen samples; full adds the done event.
    task automatic push_sweep(logic [15:0] fs, logic [15:0] st,
                              int n, int dw, logic [15:0] ip,
                              int nwen, bit full);
        int          dwe;
        int          cnt;
        logic [15:0] f;
        dwe = (dw == 0) ? 1 : dw;
        cnt = 0;
        f   = fs;
        exp_q.push_back('{K_LOAD, fs, ip});
        for (int s = 0; s <= n; s++) begin
            for (int d = 0; d < dwe; d++) begin
                if (full || cnt < nwen)
                    exp_q.push_back('{K_WEN, f, 16'h0});
                cnt++;
            end
            f = f + st;
        end
        if (full)
            exp_q.push_back('{K_DONE, 16'h0, 16'h0});
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int i;
        i = 0;
        while (busy && i < budget) begin
            tick();
            i++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    task automatic drain(string tag);
        tick();
        tick();
        chk(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic chk_quiet(string tag);
        chk({tag, "_fcw"}, 32'(fcw), 0);
        chk({tag, "_wen"}, 32'(wen), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_load_n"}, 32'(pa_load_n), 1);
    endtask

    initial begin
        cfg_we   = 1'b0;
        cfg_addr = 3'd0;
        cfg_data = 16'h0;
        start    = 1'b0;
        abort    = 1'b0;
        reset    = 1'b1;
        #2 reset = 1'b0;
        tick();
        chk_quiet("reset");
        chk("reset_init", 32'(init), 0);
        tick();
        reset = 1'b1;
        tick();

        // basic sweep
        cfg_all(16'h0100, 16'h0010, 16'd2, 16'd3, 16'h4000);
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 0, 1'b1);
        start_pulse();
        wait_idle(100);
        chk_quiet("basic_end");
        drain("basic_drain");

        // wrap-around of the fcw adder
        cfg_all(16'hFFF0, 16'h0020, 16'd1, 16'd1, 16'h1111);
        push_sweep(16'hFFF0, 16'h0020, 1, 1, 16'h1111, 0, 1'b1);
        start_pulse();
        wait_idle(100);
        drain("wrap_drain");

        // abort during the fifth sample cycle
        cfg_all(16'h0100, 16'h0010, 16'd2, 16'd3, 16'h4000);
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 5, 1'b0);
        start_pulse();
        for (int i = 0; i < 5; i++) tick();
        chk("abort_pre_wen", 32'(wen), 1);
        chk("abort_pre_fcw", 32'(fcw), 32'h0110);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_quiet("abort");
        drain("abort_drain");
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 0, 1'b1);
        start_pulse();
        wait_idle(100);
        drain("rerun_drain");

        // start together with abort stays idle
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_quiet("start_abort");
        drain("start_abort_drain");

        // config write while running is dropped
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 0, 1'b1);
        start_pulse();
        tick();
        tick();
        cfg_write(3'd1, 16'h0FFF);
        wait_idle(100);
        drain("busy_cfg_drain");

        // start held through done restarts one more sweep
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 0, 1'b1);
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 0, 1'b1);
        start = 1'b1;
        tick();
        wait_idle(100);
        tick();
        start = 1'b0;
        wait_idle(100);
        drain("restart_drain");

        // dwell 0 and step_count 0 give one sample
        cfg_all(16'h1234, 16'h0001, 16'd0, 16'd0, 16'h0042);
        push_sweep(16'h1234, 16'h0001, 0, 0, 16'h0042, 0, 1'b1);
        start_pulse();
        wait_idle(100);
        drain("degen_drain");

        // asynchronous reset in the middle of a run
        cfg_all(16'h0100, 16'h0010, 16'd2, 16'd3, 16'h4000);
        push_sweep(16'h0100, 16'h0010, 2, 3, 16'h4000, 2, 1'b0);
        start_pulse();
        for (int i = 0; i < 3; i++) tick();
        chk("areset_pre_wen", 32'(wen), 1);
        #2 reset = 1'b0;
        #1;
        chk_quiet("areset");
        chk("areset_init", 32'(init), 0);
        tick();
        reset = 1'b1;
        drain("areset_drain");
        push_sweep(16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 1'b1);
        start_pulse();
        wait_idle(100);
        drain("default_drain");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
